// File: rtl/mac_writeback.sv
// Packed-lane multiply-accumulate with one SRAM write per row.
// Optional macro MAC_WB_SATURATE_EN clamps write data to the signed 16-bit range.
module mac_writeback #(
  parameter int ACC_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  elem_size,
  input  logic [7:0]  row_words,
  input  logic [7:0]  num_rows,
  input  logic [11:0] out_base_addr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  input  logic [15:0] wt_data,
  output logic [11:0] dut_sram_write_address,
  output logic [15:0] dut_sram_write_data,
  output logic        dut_sram_write_enable,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int SUM_W = 40;

  state_t r_state;
  state_t w_next;

  logic [1:0]              r_elem_size;
  logic [7:0]              r_row_words;
  logic [7:0]              r_num_rows;
  logic [11:0]             r_base;
  logic [7:0]              r_word_cnt;
  logic [7:0]              r_row_idx;
  logic signed [ACC_W-1:0] r_acc;

  logic signed [SUM_W-1:0] w_sum2;
  logic signed [SUM_W-1:0] w_sum4;
  logic signed [SUM_W-1:0] w_sum8;
  logic signed [SUM_W-1:0] w_sum16;
  logic signed [SUM_W-1:0] w_beat_sum;
  logic                    w_last_word;
  logic                    w_last_row;
  logic                    w_cfg_empty;
  logic [15:0]             w_row_data;
  logic [11:0]             w_row_addr;

  // Every lane is sign-extended before multiplying so the products stay exact.
  always_comb begin : lane_sums
    logic signed [1:0]  a2, b2;
    logic signed [3:0]  p2;
    logic signed [3:0]  a4, b4;
    logic signed [7:0]  p4;
    logic signed [7:0]  a8, b8;
    logic signed [15:0] p8;
    logic signed [15:0] a16, b16;
    logic signed [31:0] p16;
    w_sum2  = '0;
    w_sum4  = '0;
    w_sum8  = '0;
    w_sum16 = '0;
    a2 = '0; b2 = '0; p2 = '0;
    a4 = '0; b4 = '0; p4 = '0;
    a8 = '0; b8 = '0; p8 = '0;
    for (int i = 0; i < 8; i++) begin
      a2 = in_data[2*i +: 2];
      b2 = wt_data[2*i +: 2];
      p2 = 4'(a2) * 4'(b2);
      w_sum2 = w_sum2 + SUM_W'(p2);
    end
    for (int i = 0; i < 4; i++) begin
      a4 = in_data[4*i +: 4];
      b4 = wt_data[4*i +: 4];
      p4 = 8'(a4) * 8'(b4);
      w_sum4 = w_sum4 + SUM_W'(p4);
    end
    for (int i = 0; i < 2; i++) begin
      a8 = in_data[8*i +: 8];
      b8 = wt_data[8*i +: 8];
      p8 = 16'(a8) * 16'(b8);
      w_sum8 = w_sum8 + SUM_W'(p8);
    end
    a16 = in_data;
    b16 = wt_data;
    p16 = 32'(a16) * 32'(b16);
    w_sum16 = SUM_W'(p16);
  end

  always_comb begin
    case (r_elem_size)
      2'b00:   w_beat_sum = w_sum2;
      2'b01:   w_beat_sum = w_sum4;
      2'b10:   w_beat_sum = w_sum8;
      default: w_beat_sum = w_sum16;
    endcase
  end

  generate
    if (ACC_W < SUM_W) begin : g_sum_hi
      logic w_unused_sum_hi;
      assign w_unused_sum_hi = ^w_beat_sum[SUM_W-1:ACC_W];
    end
  endgenerate

`ifdef MAC_WB_SATURATE_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-16){1'b0}}, 16'h7FFF};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-16){1'b1}}, 16'h8000};

  always_comb begin
    if (r_acc > SAT_MAX) begin
      w_row_data = 16'h7FFF;
    end else if (r_acc < SAT_MIN) begin
      w_row_data = 16'h8000;
    end else begin
      w_row_data = r_acc[15:0];
    end
  end
`else
  assign w_row_data = r_acc[15:0];
`endif

  assign w_last_word = (r_word_cnt == (r_row_words - 8'd1));
  assign w_last_row  = (r_row_idx == (r_num_rows - 8'd1));
  assign w_cfg_empty = (row_words == 8'd0) || (num_rows == 8'd0);
  assign w_row_addr  = r_base + {4'd0, r_row_idx};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next                 = r_state;
    in_ready               = 1'b0;
    dut_sram_write_enable  = 1'b0;
    dut_sram_write_address = '0;
    dut_sram_write_data    = '0;
    busy                   = 1'b0;
    done                   = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_next = w_cfg_empty ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid && w_last_word) begin
          w_next = WRITE;
        end
      end
      WRITE: begin
        busy                   = 1'b1;
        dut_sram_write_enable  = 1'b1;
        dut_sram_write_address = w_row_addr;
        dut_sram_write_data    = w_row_data;
        w_next                 = w_last_row ? DONE : ACCUM;
      end
      DONE: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Configuration is captured once per job; row state clears after each write.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_elem_size <= '0;
      r_row_words <= '0;
      r_num_rows  <= '0;
      r_base      <= '0;
      r_word_cnt  <= '0;
      r_row_idx   <= '0;
      r_acc       <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_elem_size <= elem_size;
            r_row_words <= row_words;
            r_num_rows  <= num_rows;
            r_base      <= out_base_addr;
            r_word_cnt  <= '0;
            r_row_idx   <= '0;
            r_acc       <= '0;
          end
        end
        ACCUM: begin
          if (in_valid) begin
            r_acc      <= r_acc + w_beat_sum[ACC_W-1:0];
            r_word_cnt <= r_word_cnt + 8'd1;
          end
        end
        WRITE: begin
          r_acc      <= '0;
          r_word_cnt <= '0;
          r_row_idx  <= r_row_idx + 8'd1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_writeback.sv
// Scoreboard bench for mac_writeback: a lane model predicts each row write,
// a forked watcher pops and compares every write strobe.
module tb_mac_writeback;

  localparam int ACC_W = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  elem_size;
  logic [7:0]  row_words;
  logic [7:0]  num_rows;
  logic [11:0] out_base_addr;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [15:0] wt_data;
  logic [11:0] dut_sram_write_address;
  logic [15:0] dut_sram_write_data;
  logic        dut_sram_write_enable;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  mac_writeback #(.ACC_W(ACC_W)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .start                  (start),
    .elem_size              (elem_size),
    .row_words              (row_words),
    .num_rows               (num_rows),
    .out_base_addr          (out_base_addr),
    .in_valid               (in_valid),
    .in_ready               (in_ready),
    .in_data                (in_data),
    .wt_data                (wt_data),
    .dut_sram_write_address (dut_sram_write_address),
    .dut_sram_write_data    (dut_sram_write_data),
    .dut_sram_write_enable  (dut_sram_write_enable),
    .busy                   (busy),
    .done                   (done)
  );

  typedef struct {
    logic [11:0] addr;
    logic [15:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_errors = 0;

  logic [1:0]  cfg_size;
  int          cfg_rw;
  int          cfg_nr;
  logic [11:0] cfg_base;

  // Reference lane arithmetic done with shifts and masks on plain integers.
  function automatic longint lane_sum(logic [15:0] a, logic [15:0] b, logic [1:0] sz);
    int     w;
    int     n;
    int     va;
    int     vb;
    longint s;
    w = 2 << sz;
    n = 16 / w;
    s = 0;
    for (int i = 0; i < n; i++) begin
      va = int'((a >> (i * w)) & 16'((1 << w) - 1));
      vb = int'((b >> (i * w)) & 16'((1 << w) - 1));
      if (va >= (1 << (w - 1))) va = va - (1 << w);
      if (vb >= (1 << (w - 1))) vb = vb - (1 << w);
      s = s + longint'(va) * longint'(vb);
    end
    return s;
  endfunction

  function automatic logic [15:0] row_data(longint acc);
    int v;
    v = int'(acc[31:0]);
`ifdef MAC_WB_SATURATE_EN
    if (v > 32767) return 16'h7FFF;
    if (v < -32768) return 16'h8000;
    return v[15:0];
`else
    return acc[15:0];
`endif
  endfunction

  task automatic watch_writes();
    wr_t e;
    forever begin
      @(negedge clk);
      n_checks++;
      if (dut_sram_write_enable === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("[TB] FAIL unexpected_write addr=%h data=%h", dut_sram_write_address, dut_sram_write_data);
        end else begin
          e = exp_q.pop_front();
          if (dut_sram_write_address !== e.addr || dut_sram_write_data !== e.data) begin
            n_errors++;
            $display("[TB] FAIL write_value got addr=%h data=%h expected addr=%h data=%h",
                     dut_sram_write_address, dut_sram_write_data, e.addr, e.data);
          end
        end
        n_checks++;
        if (in_ready !== 1'b0 || busy !== 1'b1) begin
          n_errors++;
          $display("[TB] FAIL write_cycle_flags got in_ready=%b busy=%b expected in_ready=0 busy=1", in_ready, busy);
        end
      end else if (dut_sram_write_enable !== 1'b0 || dut_sram_write_address !== 12'h000 || dut_sram_write_data !== 16'h0000) begin
        n_errors++;
        $display("[TB] FAIL idle_write_bus got we=%b addr=%h data=%h expected 0 0 0",
                 dut_sram_write_enable, dut_sram_write_address, dut_sram_write_data);
      end
    end
  endtask

  task automatic start_job(input logic [1:0] sz, input int rw, input int nr, input logic [11:0] base);
    @(posedge clk);
    #1;
    start         = 1'b1;
    elem_size     = sz;
    row_words     = 8'(rw);
    num_rows      = 8'(nr);
    out_base_addr = base;
    cfg_size      = sz;
    cfg_rw        = rw;
    cfg_nr        = nr;
    cfg_base      = base;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // gap_mode: 0 none, 1 one idle cycle before every beat, 2 random idles.
  task automatic feed_job(input int gap_mode, input logic [15:0] fin, input logic [15:0] fwt, input bit rnd);
    longint acc;
    int     guard;
    wr_t    e;
    for (int r = 0; r < cfg_nr; r++) begin
      acc = 0;
      for (int w = 0; w < cfg_rw; w++) begin
        in_valid = 1'b0;
        if (gap_mode == 1) begin
          @(posedge clk);
          #1;
        end else if (gap_mode == 2) begin
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
        end
        in_valid = 1'b1;
        in_data  = rnd ? 16'($urandom) : fin;
        wt_data  = rnd ? 16'($urandom) : fwt;
        guard    = 0;
        while (in_ready !== 1'b1 && guard < 50) begin
          @(posedge clk);
          #1;
          guard++;
        end
        if (guard >= 50) begin
          n_checks++;
          n_errors++;
          $display("[TB] FAIL handshake_timeout in_ready=%b expected 1", in_ready);
          in_valid = 1'b0;
          return;
        end
        acc = acc + lane_sum(in_data, wt_data, cfg_size);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (w == cfg_rw - 1) begin
          e.addr = cfg_base + 12'(r);
          e.data = row_data(acc);
          exp_q.push_back(e);
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; in_valid = 1'b0;
    elem_size = 2'b00; row_words = 8'd0; num_rows = 8'd0; out_base_addr = 12'h000;
    in_data = 16'h0000; wt_data = 16'h0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_errors++;
      $display("[TB] FAIL reset_flags got in_ready=%b busy=%b done=%b expected 0 0 0", in_ready, busy, done);
    end
    n_checks++;
    if (dut_sram_write_enable !== 1'b0 || dut_sram_write_address !== 12'h000 || dut_sram_write_data !== 16'h0000) begin
      n_errors++;
      $display("[TB] FAIL reset_write_bus got we=%b addr=%h data=%h expected 0", dut_sram_write_enable, dut_sram_write_address, dut_sram_write_data);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_basic_8b();
    start_job(2'b10, 1, 1, 12'h100);
    feed_job(0, 16'h0302, 16'h0504, 1'b0);
    @(negedge clk);
    n_checks++;
    if (dut_sram_write_enable !== 1'b1) begin
      n_errors++;
      $display("[TB] FAIL basic_write_latency got we=%b expected 1", dut_sram_write_enable);
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_errors++;
      $display("[TB] FAIL basic_done got done=%b busy=%b expected done=1 busy=0", done, busy);
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || exp_q.size() != 0) begin
      n_errors++;
      $display("[TB] FAIL basic_after_done got done=%b pending=%0d expected 0 0", done, exp_q.size());
    end
  endtask

  task automatic test_2b();
    start_job(2'b00, 1, 1, 12'h020);
    feed_job(0, 16'hFFFF, 16'h5555, 1'b0);
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (done !== 1'b1 || exp_q.size() != 0) begin
      n_errors++;
      $display("[TB] FAIL lanes2b_done got done=%b pending=%0d expected 1 0", done, exp_q.size());
    end
  endtask

  task automatic test_16b_gaps();
    start_job(2'b11, 3, 2, 12'h040);
    feed_job(1, 16'd2, 16'd100, 1'b0);
    @(negedge clk);
    n_checks++;
    if (dut_sram_write_enable !== 1'b1) begin
      n_errors++;
      $display("[TB] FAIL gaps_last_write got we=%b expected 1", dut_sram_write_enable);
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b1 || exp_q.size() != 0) begin
      n_errors++;
      $display("[TB] FAIL gaps_done got done=%b pending=%0d expected 1 0", done, exp_q.size());
    end
  endtask

  task automatic test_overflow();
    start_job(2'b11, 1, 1, 12'h300);
    feed_job(0, 16'h7FFF, 16'h7FFF, 1'b0);
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (done !== 1'b1 || exp_q.size() != 0) begin
      n_errors++;
      $display("[TB] FAIL overflow_done got done=%b pending=%0d expected 1 0", done, exp_q.size());
    end
  endtask

  task automatic test_reset_midrow();
    start_job(2'b01, 4, 1, 12'h050);
    in_valid = 1'b1;
    in_data  = 16'h1234;
    wt_data  = 16'h4321;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    reset    = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0 || done !== 1'b0 || dut_sram_write_enable !== 1'b0) begin
      n_errors++;
      $display("[TB] FAIL midrow_reset got busy=%b in_ready=%b done=%b we=%b expected 0 0 0 0",
               busy, in_ready, done, dut_sram_write_enable);
    end
    start_job(2'b01, 2, 1, 12'h051);
    feed_job(0, 16'h0000, 16'h0000, 1'b1);
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (done !== 1'b1 || exp_q.size() != 0) begin
      n_errors++;
      $display("[TB] FAIL midrow_restart got done=%b pending=%0d expected 1 0", done, exp_q.size());
    end
  endtask

  task automatic test_zero_rows();
    for (int k = 0; k < 2; k++) begin
      if (k == 0) start_job(2'b10, 3, 0, 12'h0AA);
      else        start_job(2'b10, 0, 5, 12'h0AB);
      @(negedge clk);
      n_checks++;
      if (done !== 1'b1 || busy !== 1'b0) begin
        n_errors++;
        $display("[TB] FAIL zero_job_done case=%0d got done=%b busy=%b expected 1 0", k, done, busy);
      end
      @(negedge clk);
      n_checks++;
      if (done !== 1'b0) begin
        n_errors++;
        $display("[TB] FAIL zero_job_pulse case=%0d got done=%b expected 0", k, done);
      end
    end
  endtask

  task automatic test_addr_wrap();
    int cyc;
    start_job(2'b10, 2, 2, 12'hFFF);
    feed_job(0, 16'h0000, 16'h0000, 1'b1);
    cyc = 0;
    while (done !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (done !== 1'b1 || exp_q.size() != 0) begin
      n_errors++;
      $display("[TB] FAIL wrap_done got done=%b pending=%0d expected 1 0", done, exp_q.size());
    end
  endtask

  task automatic test_start_ignored();
    int cyc;
    start_job(2'b01, 2, 1, 12'h200);
    start         = 1'b1;
    row_words     = 8'd7;
    num_rows      = 8'd0;
    out_base_addr = 12'h000;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_errors++;
      $display("[TB] FAIL start_ignored got busy=%b done=%b expected 1 0", busy, done);
    end
    feed_job(0, 16'h0000, 16'h0000, 1'b1);
    cyc = 0;
    while (done !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (done !== 1'b1 || exp_q.size() != 0) begin
      n_errors++;
      $display("[TB] FAIL start_ignored_done got done=%b pending=%0d expected 1 0", done, exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    for (int j = 0; j < 6; j++) begin
      start_job(2'($urandom_range(0, 3)), $urandom_range(1, 4), $urandom_range(1, 3), 12'($urandom));
      feed_job(2, 16'h0000, 16'h0000, 1'b1);
      cyc = 0;
      while (done !== 1'b1 && cyc < 20) begin
        @(negedge clk);
        cyc++;
      end
      n_checks++;
      if (done !== 1'b1 || busy !== 1'b0 || exp_q.size() != 0) begin
        n_errors++;
        $display("[TB] FAIL b2b_done job=%0d got done=%b busy=%b pending=%0d expected 1 0 0", j, done, busy, exp_q.size());
      end
    end
  endtask

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    in_valid = 1'b0;
    fork
      watch_writes();
    join_none
    test_reset();
    test_basic_8b();
    test_2b();
    test_16b_gaps();
    test_overflow();
    test_reset_midrow();
    test_zero_rows();
    test_addr_wrap();
    test_start_ignored();
    test_back_to_back();
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
